// File: rtl/and_delay_monitor.sv
// Per-tap settle-time monitor for the AND delay chain: counts clk cycles from an A/B change
// until each tap equals A&B. Optional `SYNC_EN adds 2-flop input synchronisers.
module and_delay_monitor #(
  parameter int unsigned NTAP    = 5,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_in,
  input  logic                  b_in,
  input  logic [NTAP-1:0]       and_out,
  output logic                  busy,
  output logic                  meas_valid,
  output logic [NTAP*CNT_W-1:0] tap_delay,
  output logic [NTAP-1:0]       tap_timeout,
  output logic                  overrun
);

  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_DONE
  } state_t;

  logic                  w_a;
  logic                  w_b;
  logic [NTAP-1:0]       w_taps;

`ifdef SYNC_EN
  logic [NTAP+1:0]       r_sync1;
  logic [NTAP+1:0]       r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {a_in, b_in, and_out};
      r_sync2 <= r_sync1;
    end
  end

  assign w_a    = r_sync2[NTAP+1];
  assign w_b    = r_sync2[NTAP];
  assign w_taps = r_sync2[NTAP-1:0];
`else
  assign w_a    = a_in;
  assign w_b    = b_in;
  assign w_taps = and_out;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_ab_q;
  logic                  r_exp;
  logic [CNT_W-1:0]      r_cnt;
  logic [NTAP-1:0]       r_settled;
  logic [NTAP*CNT_W-1:0] r_work_delay;
  logic [NTAP-1:0]       r_work_to;
  logic [NTAP*CNT_W-1:0] r_tap_delay;
  logic [NTAP-1:0]       r_tap_timeout;
  logic                  r_meas_valid;
  logic                  r_overrun;

  logic                  w_chg;
  logic                  w_exp_new;
  logic                  w_at_timeout;
  logic [NTAP-1:0]       w_match;
  logic [NTAP-1:0]       w_settled_nxt;
  logic                  w_all_settled;
  logic                  w_start;
  logic                  w_commit;
  logic                  w_abort;

  assign w_chg        = ({w_a, w_b} != r_ab_q);
  assign w_exp_new    = w_a & w_b;
  assign w_at_timeout = (r_cnt == LP_TIMEOUT);

  // Only a known equal value counts as a match; X/Z on a tap fails the if and stays unmatched.
  always_comb begin
    w_match = '0;
    for (int unsigned i = 0; i < NTAP; i++) begin
      if (w_taps[i] == r_exp) begin
        w_match[i] = 1'b1;
      end
    end
    w_settled_nxt = r_settled | w_match;
    w_all_settled = &w_settled_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_commit    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_chg) begin
          w_state_nxt = S_MEASURE;
          w_start     = 1'b1;
        end
      end
      S_MEASURE: begin
        if (w_chg) begin
          w_start = 1'b1;
          w_abort = 1'b1;
        end else if (w_all_settled || w_at_timeout) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (w_chg) begin
          w_state_nxt = S_MEASURE;
          w_start     = 1'b1;
          w_abort     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_commit    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ab_q  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_ab_q  <= {w_a, w_b};
    end
  end

  // Working results live apart from the published outputs so an aborted run never disturbs them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exp        <= 1'b0;
      r_cnt        <= '0;
      r_settled    <= '0;
      r_work_delay <= '0;
      r_work_to    <= '0;
    end else if (w_start) begin
      r_exp        <= w_exp_new;
      r_cnt        <= '0;
      r_settled    <= '0;
      r_work_delay <= '0;
      r_work_to    <= '0;
    end else if (r_state == S_MEASURE) begin
      for (int unsigned i = 0; i < NTAP; i++) begin
        if (!r_settled[i]) begin
          if (w_match[i]) begin
            r_work_delay[i*CNT_W +: CNT_W] <= r_cnt;
          end else if (w_at_timeout) begin
            r_work_delay[i*CNT_W +: CNT_W] <= LP_TIMEOUT;
            r_work_to[i]                   <= 1'b1;
          end
        end
      end
      r_settled <= w_settled_nxt;
      if (!w_at_timeout) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tap_delay   <= '0;
      r_tap_timeout <= '0;
      r_meas_valid  <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_meas_valid <= w_commit;
      r_overrun    <= w_abort;
      if (w_commit) begin
        r_tap_delay   <= r_work_delay;
        r_tap_timeout <= r_work_to;
      end
    end
  end

  assign busy        = (r_state == S_MEASURE);
  assign meas_valid  = r_meas_valid;
  assign overrun     = r_overrun;
  assign tap_delay   = r_tap_delay;
  assign tap_timeout = r_tap_timeout;

endmodule

// File: tb/tb_and_delay_monitor.sv
// Self-checking bench for and_delay_monitor: table of stimulus/expected records with a
// scoreboard queue, plus hand-written reset-abort and overrun sequences.
module tb_and_delay_monitor;

  localparam int unsigned NTAP  = 5;
  localparam int unsigned CNT_W = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  a_in;
  logic                  b_in;
  logic [NTAP-1:0]       and_out;
  logic                  busy;
  logic                  meas_valid;
  logic [NTAP*CNT_W-1:0] tap_delay;
  logic [NTAP-1:0]       tap_timeout;
  logic                  overrun;

  and_delay_monitor #(
    .NTAP    (NTAP),
    .CNT_W   (CNT_W),
    .TIMEOUT (200)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .a_in        (a_in),
    .b_in        (b_in),
    .and_out     (and_out),
    .busy        (busy),
    .meas_valid  (meas_valid),
    .tap_delay   (tap_delay),
    .tap_timeout (tap_timeout),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                  a;
    logic                  b;
    logic [NTAP-1:0][7:0]  rise;      // edges after the A/B change at which tap i takes its new value
    logic [NTAP-1:0]       stuck;
    logic [NTAP-1:0]       stuck_val;
    logic [NTAP*CNT_W-1:0] exp_delay;
    logic [NTAP-1:0]       exp_to;
  } vec_t;

  typedef struct packed {
    logic [NTAP*CNT_W-1:0] d;
    logic [NTAP-1:0]       t;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  int   n_overrun = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      n_valid++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_meas_valid actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("tap_delay", 64'(tap_delay), 64'(e.d));
        chk("tap_timeout", 64'(tap_timeout), 64'(e.t));
      end
    end
    if (overrun === 1'b1) n_overrun++;
  end

  task automatic set_taps(input vec_t v, input int unsigned k);
    for (int unsigned i = 0; i < NTAP; i++) begin
      if (v.rise[i] == 8'(k)) begin
        and_out[i] = v.stuck[i] ? v.stuck_val[i] : (v.a & v.b);
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int unsigned maxr;
    int          start_valid;
    int          c;
    exp_t        e;
    @(posedge clk); #1;
    a_in = v.a;
    b_in = v.b;
    set_taps(v, 0);
    e.d = v.exp_delay;
    e.t = v.exp_to;
    sb.push_back(e);
    start_valid = n_valid;
    maxr = 0;
    for (int unsigned i = 0; i < NTAP; i++) if (32'(v.rise[i]) > maxr) maxr = 32'(v.rise[i]);
    for (int unsigned k = 1; k <= maxr; k++) begin
      @(posedge clk); #1;
      set_taps(v, k);
    end
    c = 0;
    while (n_valid == start_valid && c < 400) begin
      @(posedge clk); #1;
      c++;
    end
    if (n_valid == start_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_meas_valid_timeout actual=0 required=1", name);
      if (sb.size() != 0) void'(sb.pop_back());
    end
  endtask

  vec_t tbl[6];
  vec_t v_ovr;
  int   ov0;
  int   nv0;

  initial begin
    //             a     b     rise (tap4..tap0)              stuck     stuck_val exp_delay (tap4..tap0)  exp_to
    tbl[0] = '{1'b1, 1'b1, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1},  5'b00000, 5'b00000, 40'h04_03_02_01_00, 5'b00000};
    tbl[1] = '{1'b1, 1'b0, {8'd1, 8'd1, 8'd1, 8'd1, 8'd1},  5'b00100, 5'b00100, 40'h00_00_C8_00_00, 5'b00100};
    tbl[2] = '{1'b0, 1'b0, {8'd1, 8'd1, 8'd1, 8'd1, 8'd1},  5'b00000, 5'b00000, 40'h00_00_00_00_00, 5'b00000};
    tbl[3] = '{1'b0, 1'b1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0},  5'b00000, 5'b00000, 40'h00_00_00_00_00, 5'b00000};
    tbl[4] = '{1'b1, 1'b1, {8'd2, 8'd1, 8'd7, 8'd0, 8'd3},  5'b00000, 5'b00000, 40'h01_00_06_00_02, 5'b00000};
    tbl[5] = '{1'b0, 1'b1, {8'd10, 8'd1, 8'd1, 8'd1, 8'd1}, 5'b00000, 5'b00000, 40'h09_00_00_00_00, 5'b00000};
    v_ovr  = '{1'b0, 1'b1, {8'd6, 8'd5, 8'd4, 8'd3, 8'd2},  5'b00000, 5'b00000, 40'h05_04_03_02_01, 5'b00000};

    reset = 1'b1;
    a_in = 1'b0;
    b_in = 1'b0;
    and_out = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_meas_valid", 64'(meas_valid), 64'(0));
    chk("rst_overrun", 64'(overrun), 64'(0));
    chk("rst_tap_delay", 64'(tap_delay), 64'(0));
    chk("rst_tap_timeout", 64'(tap_timeout), 64'(0));
    reset = 1'b0;
    repeat (4) @(posedge clk);

    for (int unsigned n = 0; n < 6; n++) begin
      run_vec(tbl[n], $sformatf("vec%0d", n));
      repeat (5) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_hold_delay", n), 64'(tap_delay), 64'(tbl[n].exp_delay));
      chk($sformatf("vec%0d_hold_to", n), 64'(tap_timeout), 64'(tbl[n].exp_to));
      chk($sformatf("vec%0d_idle_busy", n), 64'(busy), 64'(0));
    end
    chk("table_overruns", 64'(n_overrun), 64'(0));

    // Reset in the middle of a measurement: silent abort, everything cleared.
    @(posedge clk); #1;
    a_in = 1'b1;
    b_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrun_busy", 64'(busy), 64'(1));
    ov0 = n_overrun;
    nv0 = n_valid;
    a_in = 1'b0;
    b_in = 1'b0;
    and_out = '0;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_tap_delay", 64'(tap_delay), 64'(0));
    chk("midrst_tap_timeout", 64'(tap_timeout), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("postrst_no_valid", 64'(n_valid - nv0), 64'(0));
    chk("postrst_no_overrun", 64'(n_overrun - ov0), 64'(0));
    chk("postrst_busy", 64'(busy), 64'(0));

    // Change on the third measurement cycle: overrun, aborted run silent, second run reported.
    and_out = '1;
    repeat (4) @(posedge clk);
    #1;
    ov0 = n_overrun;
    a_in = 1'b1;
    b_in = 1'b0;
    repeat (2) @(posedge clk);
    run_vec(v_ovr, "overrun_run");
    repeat (5) @(posedge clk);
    #1;
    chk("overrun_pulses", 64'(n_overrun - ov0), 64'(1));
    chk("overrun_hold_delay", 64'(tap_delay), 64'(v_ovr.exp_delay));

    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
